imem_loadable: RTL and testbench
================================

# imem_loadable

Parametrised instruction memory for the single-cycle MIPS core. It replaces a fixed, pre-initialised word array with a RAM that is filled at run time through a valid/ready load port, and a three-state controller (EMPTY/LOAD/RUN) gates fetches. Fetch addressing is byte-based and word-aligned, with misalignment and out-of-range detection. Fetch read latency is selectable (combinational or registered). The block sits between the PC register and the instruction decoder; it holds the core (via `stall`) until a program is loaded.

## Interface
- `DATA_WIDTH`, 32: instruction word width.
- `ADDR_WIDTH`, 32: PC width (byte address).
- `DEPTH`, 256: number of words; power of two, ≥2; `AW = log2(DEPTH)`.
- `REG_OUT`, 0: 0 = combinational fetch; 1 = registered fetch, 1-cycle latency.
- `NOP_WORD`, 0: word driven on `instr` whenever no valid instruction is available.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `pc` in ADDR_WIDTH: fetch byte address.
- `instr` out DATA_WIDTH: fetched instruction.
- `instr_valid` out 1: `instr` is a real loaded word.
- `misaligned` out 1: `pc[1:0] != 0` during RUN.
- `out_of_range` out 1: word index is at or beyond `loaded_words` during RUN.
- `stall` out 1: high in EMPTY and LOAD.
- `ld_start` in 1: begin or restart a load.
- `ld_valid` in 1: `ld_data` is offered.
- `ld_data` in DATA_WIDTH: word to write.
- `ld_last` in 1: qualifies the final word of a load.
- `ld_ready` out 1: high only in LOAD.
- `loaded_words` out AW+1: count of words written in the current or last load.

## Operation
- States:
  - EMPTY (reset state).
  - LOAD.
  - RUN.
- Transitions:
  - From any state, `ld_start` goes to LOAD. `wptr` ← 0 and `loaded_words` ← 0. Any `ld_valid` in that same cycle is ignored.
  - In LOAD, a handshake (`ld_valid & ld_ready`) writes `mem[wptr] ← ld_data`, increments `wptr` and increments `loaded_words`.
  - LOAD goes to RUN when a handshake carries `ld_last`, or when the handshake writes index `DEPTH-1` (auto-terminate).
  - RUN stays in RUN until the next `ld_start`.
  - `ld_start` together with a handshake takes priority: the state restarts and the word is dropped.
- Word index = `pc[AW+1:2]`. PC bits above `AW+1` that are nonzero also force `out_of_range`.
- Fetch result, by priority:
  1. Not in RUN: `instr` = `NOP_WORD`, `instr_valid` = 0, flags 0.
  2. In RUN and `misaligned`: `NOP_WORD`, `instr_valid` = 0.
  3. In RUN and `out_of_range`: `NOP_WORD`, `instr_valid` = 0.
  4. Otherwise: `instr` = `mem[index]`, `instr_valid` = 1.
- Memory contents are not reset. Validity comes only from `loaded_words`, so stale words from an earlier load are never reported valid beyond the new count.
- Reset values:
  - state = EMPTY, `wptr` = 0, `loaded_words` = 0.
  - `stall` = 1, `ld_ready` = 0, `instr_valid` = 0, `misaligned` = 0, `out_of_range` = 0, `instr` = `NOP_WORD`.
  - With REG_OUT = 1, the output registers are also cleared by reset.
- A reset in mid-load aborts the load: state EMPTY, count 0.

## Timing
- `ld_start` sampled at edge N: `ld_ready` is high from cycle N+1.
- Each handshake completes in one cycle. `loaded_words` shows the new count after that edge.
- Accepting `ld_last` at edge M: RUN in cycle M+1. `stall` and `ld_ready` fall in cycle M+1.
- REG_OUT = 0: `instr` and the flags follow `pc` and state combinationally within the same cycle. A word written at edge M is readable from cycle M+1.
- REG_OUT = 1: `instr` and all flags are registered and reflect the `pc` and state sampled at the previous edge. In the first RUN cycle the outputs still show the LOAD-state values (NOP, invalid).
- `stall` is always combinational from state, regardless of REG_OUT.

## Test plan
- Reset, then `pc`=0 → `stall`=1, `instr`=`NOP_WORD`, `instr_valid`=0, `ld_ready`=0.
- Load 3 words 0x20080005, 0x20090003, 0x01095020 (`ld_last` on the third) → `loaded_words`=3. RUN next cycle. `pc`=0/4/8 return the words with `instr_valid`=1. `pc`=12 → NOP and `out_of_range`=1.
- In RUN with `pc`=6 → `misaligned`=1, `instr`=NOP, `instr_valid`=0.
- Backpressure: toggle `ld_valid` at random through a 10-word load → exactly the offered words land at indices 0..9 in order.
- Restart: `ld_start` asserted with `ld_valid` high after 2 words → that word is dropped and `loaded_words`=0. Load 1 word → `pc`=4 reports `out_of_range` even though a stale word is present. Also load `DEPTH` words with no `ld_last` → auto RUN after word `DEPTH-1`.
- Assert `reset` mid-load, then with REG_OUT=1 load and fetch `pc`=0 → EMPTY immediately. After reload, `instr` appears one cycle after `pc` is applied.

Source files
------------

// File: rtl/imem_loadable.sv
// Loadable instruction memory for the single-cycle MIPS core.
// A valid/ready load port fills the word RAM at run time. An EMPTY/LOAD/RUN
// controller holds the core in stall until a program is resident, and it
// gates fetches with alignment and range checks.
module imem_loadable #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter int                    REG_OUT    = 0,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_WIDTH-1:0]       pc,
  output logic [DATA_WIDTH-1:0]       instr,
  output logic                        instr_valid,
  output logic                        misaligned,
  output logic                        out_of_range,
  output logic                        stall,
  input  logic                        ld_start,
  input  logic                        ld_valid,
  input  logic [DATA_WIDTH-1:0]       ld_data,
  input  logic                        ld_last,
  output logic                        ld_ready,
  output logic [$clog2(DEPTH):0]      loaded_words
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

  state_t                  state;
  logic [AW-1:0]           wptr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    running;
  logic                    wr_en;
  logic [AW-1:0]           idx;
  logic                    hi_nz;
  logic                    mis_c;
  logic                    oor_c;
  logic                    val_c;
  logic [DATA_WIDTH-1:0]   instr_c;

  assign running  = (state == RUN);
  assign ld_ready = (state == LOAD);
  assign stall    = !running;
  // A restart in the same cycle as a handshake wins and drops the word.
  assign wr_en    = ld_ready && ld_valid && !ld_start;

  // Load controller: restart, accept words, finish on ld_last or a full array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= EMPTY;
      wptr         <= '0;
      loaded_words <= '0;
    end else if (ld_start) begin
      state        <= LOAD;
      wptr         <= '0;
      loaded_words <= '0;
    end else if (wr_en) begin
      wptr         <= wptr + 1'b1;
      loaded_words <= loaded_words + 1'b1;
      if (ld_last || (&wptr))
        state <= RUN;
    end
  end

  // The word store is not reset. Validity comes from loaded_words alone.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wptr] <= ld_data;
  end

  // Fetch decode: word index, alignment and range checks, priority-muxed result.
  always_comb begin
    idx     = pc[AW+1:2];
    hi_nz   = |(pc >> (AW + 2));
    mis_c   = running && (pc[1:0] != 2'b00);
    oor_c   = running && (hi_nz || ({1'b0, idx} >= loaded_words));
    val_c   = running && !mis_c && !oor_c;
    instr_c = val_c ? mem[idx] : NOP_WORD;
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      // Registered fetch: outputs reflect pc and state from the previous edge.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          instr        <= NOP_WORD;
          instr_valid  <= 1'b0;
          misaligned   <= 1'b0;
          out_of_range <= 1'b0;
        end else begin
          instr        <= instr_c;
          instr_valid  <= val_c;
          misaligned   <= mis_c;
          out_of_range <= oor_c;
        end
      end
    end else begin : g_comb_out
      assign instr        = instr_c;
      assign instr_valid  = val_c;
      assign misaligned   = mis_c;
      assign out_of_range = oor_c;
    end
  endgenerate

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable. It runs a combinational-fetch instance and a
// registered-fetch instance side by side on shared stimulus. Expected fetch
// results are queued when pc is driven. Each queue is popped when its instance
// presents the result.
module tb_imem_loadable;

  localparam int          DW    = 32;
  localparam int          AWID  = 32;
  localparam int          DEP   = 16;
  localparam logic [31:0] NOP   = 32'h0BAD_F00D;

  typedef logic [34:0] exp_t; // {instr, valid, misaligned, out_of_range}

  logic            clk = 1'b0;
  logic            reset;
  logic [AWID-1:0] pc;
  logic            ld_start, ld_valid, ld_last;
  logic [DW-1:0]   ld_data;

  logic [DW-1:0]   instr0, instr1;
  logic            v0, v1, m0, m1, o0, o1, st0, st1, rdy0, rdy1;
  logic [4:0]      lw0, lw1;

  int              n_cmp = 0;
  int              n_bad = 0;
  logic [31:0]     exp_mem [DEP];
  int              cnt = 0;
  exp_t            q0[$];
  exp_t            q1[$];

  always #5 clk = ~clk;

  imem_loadable #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWID), .DEPTH(DEP), .REG_OUT(0), .NOP_WORD(NOP)) u0 (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr0), .instr_valid(v0),
    .misaligned(m0), .out_of_range(o0), .stall(st0), .ld_start(ld_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(rdy0), .loaded_words(lw0));

  imem_loadable #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWID), .DEPTH(DEP), .REG_OUT(1), .NOP_WORD(NOP)) u1 (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr1), .instr_valid(v1),
    .misaligned(m1), .out_of_range(o1), .stall(st1), .ld_start(ld_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(rdy1), .loaded_words(lw1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t expect_fetch(input logic [31:0] a);
    logic mis, oor, v;
    logic [3:0] ix;
    ix  = a[5:2];
    mis = (a[1:0] != 2'b00);
    oor = ((a >> 6) != 0) || (int'(ix) >= cnt);
    v   = !mis && !oor;
    return {(v ? exp_mem[ix] : NOP), v, mis, oor};
  endfunction

  task automatic pop_check(input string tag, input int which, input exp_t obs);
    exp_t e;
    if (which == 0) begin
      if (q0.size() == 0) begin check({tag, "_q0_empty"}, 64'd0, 64'd1); return; end
      e = q0.pop_front();
    end else begin
      if (q1.size() == 0) begin check({tag, "_q1_empty"}, 64'd0, 64'd1); return; end
      e = q1.pop_front();
    end
    check(tag, {29'd0, obs}, {29'd0, e});
  endtask

  task automatic fetch(input logic [31:0] a);
    exp_t e;
    e = expect_fetch(a);
    q0.push_back(e);
    q1.push_back(e);
    pc = a;
    #1;
    pop_check($sformatf("comb_fetch_pc%0d", a), 0, {instr0, v0, m0, o0});
    cyc();
    pop_check($sformatf("reg_fetch_pc%0d", a), 1, {instr1, v1, m1, o1});
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    cyc();
    ld_start = 1'b0;
    cnt = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    cyc();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    exp_mem[cnt % DEP] = d;
    cnt++;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_stall0"}, 64'(st0), 64'd1);
    check({tag, "_stall1"}, 64'(st1), 64'd1);
    check({tag, "_rdy0"}, 64'(rdy0), 64'd0);
    check({tag, "_lw0"}, 64'(lw0), 64'd0);
    check({tag, "_out0"}, {29'd0, instr0, v0, m0, o0}, {29'd0, NOP, 3'b000});
    check({tag, "_out1"}, {29'd0, instr1, v1, m1, o1}, {29'd0, NOP, 3'b000});
  endtask

  initial begin
    int i;
    int guard;
    logic v;
    logic [31:0] bp [10];

    reset = 1'b1; pc = '0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk) reset = 1'b0;
    cyc();
    check_idle("post_reset");

    // Three-word program with ld_last on the third word.
    start_load();
    check("start_rdy0", 64'(rdy0), 64'd1);
    check("start_rdy1", 64'(rdy1), 64'd1);
    send(32'h2008_0005, 1'b0);
    check("lw_after1", 64'(lw0), 64'd1);
    send(32'h2009_0003, 1'b0);
    send(32'h0109_5020, 1'b1);
    check("lw3", 64'(lw0), 64'd3);
    check("run_stall0", 64'(st0), 64'd0);
    check("run_stall1", 64'(st1), 64'd0);
    check("run_rdy0", 64'(rdy0), 64'd0);
    check("first_run_reg", {29'd0, instr1, v1, m1, o1}, {29'd0, NOP, 3'b000});
    fetch(32'd0);
    fetch(32'd4);
    fetch(32'd8);
    fetch(32'd12);
    fetch(32'd6);

    // Ten-word load with a randomly toggling ld_valid.
    for (int k = 0; k < 10; k++) bp[k] = 32'h1000_0000 | (k * 32'h0001_0101);
    start_load();
    i = 0;
    guard = 0;
    while (i < 10 && guard < 400) begin
      v = 1'($urandom_range(0, 1));
      ld_valid = v;
      ld_data  = v ? bp[i] : $urandom;
      ld_last  = (i == 9);
      cyc();
      if (v) begin
        exp_mem[i] = bp[i];
        i++;
        cnt = i;
      end
      guard++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check("bp_all_sent", 64'(i), 64'd10);
    check("bp_lw", 64'(lw0), 64'd10);
    for (int k = 0; k <= 10; k++) fetch(32'(k * 4));

    // Restart with a concurrent word offered, then a one-word load.
    start_load();
    send(32'hAAAA_0001, 1'b0);
    send(32'hBBBB_0002, 1'b0);
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 32'hCCCC_0003;
    cyc();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    cnt = 0;
    check("restart_lw", 64'(lw0), 64'd0);
    check("restart_rdy", 64'(rdy0), 64'd1);
    send(32'hDDDD_0004, 1'b1);
    check("one_word_lw", 64'(lw0), 64'd1);
    fetch(32'd0);
    fetch(32'd4);

    // Fill every word without ld_last. The last index ends the load.
    start_load();
    for (int k = 0; k < DEP - 1; k++) send(32'h5000_0000 + 32'(k), 1'b0);
    check("auto_pre_stall", 64'(st0), 64'd1);
    send(32'h5000_00FF, 1'b0);
    check("auto_stall", 64'(st0), 64'd0);
    check("auto_lw", 64'(lw0), 64'(DEP));
    fetch(32'd60);
    fetch(32'd64);
    fetch(32'd0);

    // Asynchronous reset in the middle of a load.
    start_load();
    send(32'hEEEE_0001, 1'b0);
    send(32'hEEEE_0002, 1'b0);
    ld_valid = 1'b1;
    ld_data  = 32'hEEEE_0003;
    #2 reset = 1'b1;
    #1;
    check_idle("mid_reset");
    ld_valid = 1'b0;
    cnt = 0;
    @(negedge clk) reset = 1'b0;
    cyc();
    check("after_reset_rdy", 64'(rdy1), 64'd0);
    start_load();
    send(32'h1234_5678, 1'b0);
    send(32'h9ABC_DEF0, 1'b1);
    check("reload_first_run_reg", {29'd0, instr1, v1}, {29'd0, NOP, 1'b0});
    fetch(32'd0);
    fetch(32'd4);
    fetch(32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
